wave_generator: RTL and testbench

//  Programmable square-wave source. It emits a burst of pulses, or a continuous train,

---
 rtl/freq_pkg.sv | 13 +
 rtl/phase_timer.sv | 37 +++
 rtl/wave_generator.sv | 126 ++++++++++++
 tb/tb_wave_generator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared types and widths for the frequency-meter datapath
package freq_pkg;

  localparam int FREQ_WIDTH  = 32;
  localparam int PULSE_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_HIGH = 3'b010,
    ST_LOW  = 3'b100
  } gen_state_t;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter with registered zero flag
import freq_pkg::*;

module phase_timer #(
  parameter int WIDTH = FREQ_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;

  // Saturates at zero; the flag tracks the value the counter will hold next cycle.
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (count != '0) begin
      count_next = count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      zero  <= 1'b1;
    end else begin
      count <= count_next;
      zero  <= (count_next == '0);
    end
  end

endmodule

// File: rtl/wave_generator.sv
// rtl/wave_generator.sv - programmable square-wave burst / continuous source
import freq_pkg::*;

module wave_generator #(
  parameter int WIDTH  = FREQ_WIDTH,
  parameter int NWIDTH = PULSE_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [WIDTH-1:0]  high_cycles,
  input  logic [WIDTH-1:0]  low_cycles,
  input  logic [NWIDTH-1:0] n_pulses,
  output logic              busy,
  output logic              done,
  output logic              wave,
  output logic [NWIDTH-1:0] pulses_left
);

  gen_state_t       state;
  logic [WIDTH-1:0] high_rel;
  logic [WIDTH-1:0] low_rel;
  logic [WIDTH-1:0] high_in_rel;
  logic [WIDTH-1:0] low_in_rel;
  logic             cont;
  logic             timer_load;
  logic [WIDTH-1:0] timer_val;
  logic             timer_zero;
  logic             more_pulses;

  // Reload values are stored as max(len,1)-1 so zero lengths behave as one cycle.
  assign high_in_rel = (high_cycles == '0) ? '0 : high_cycles - WIDTH'(1);
  assign low_in_rel  = (low_cycles == '0)  ? '0 : low_cycles - WIDTH'(1);
  assign more_pulses = cont || (pulses_left > NWIDTH'(1));

  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    if (stop) begin
      timer_load = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          timer_load = 1'b1;
          timer_val  = high_in_rel;
        end
        ST_HIGH: if (timer_zero) begin
          timer_load = 1'b1;
          timer_val  = low_rel;
        end
        ST_LOW: if (timer_zero && more_pulses) begin
          timer_load = 1'b1;
          timer_val  = high_rel;
        end
        default: timer_load = 1'b1;
      endcase
    end
  end

  phase_timer #(.WIDTH(WIDTH)) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wave        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_left <= '0;
      high_rel    <= '0;
      low_rel     <= '0;
      cont        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state       <= ST_IDLE;
        wave        <= 1'b0;
        busy        <= 1'b0;
        pulses_left <= '0;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            state       <= ST_HIGH;
            wave        <= 1'b1;
            busy        <= 1'b1;
            high_rel    <= high_in_rel;
            low_rel     <= low_in_rel;
            cont        <= (n_pulses == '0);
            pulses_left <= n_pulses;
          end
          ST_HIGH: if (timer_zero) begin
            state <= ST_LOW;
            wave  <= 1'b0;
          end
          ST_LOW: if (timer_zero) begin
            if (more_pulses) begin
              state <= ST_HIGH;
              wave  <= 1'b1;
              if (!cont) begin
                pulses_left <= pulses_left - NWIDTH'(1);
              end
            end else begin
              state       <= ST_IDLE;
              busy        <= 1'b0;
              pulses_left <= '0;
              done        <= 1'b1;
            end
          end
          default: begin
            state       <= ST_IDLE;
            wave        <= 1'b0;
            busy        <= 1'b0;
            pulses_left <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_generator.sv
// tb/tb_wave_generator.sv - scoreboard bench for wave_generator
`timescale 1ns/1ps

module tb_wave_generator;

  localparam int EV_HIGH = 0;
  localparam int EV_LOW  = 1;
  localparam int EV_END  = 2;

  typedef struct {
    int kind;
    int val;
    int aux;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] high_cycles = '0;
  logic [31:0] low_cycles = '0;
  logic [15:0] n_pulses = '0;
  logic        busy;
  logic        done;
  logic        wave;
  logic [15:0] pulses_left;

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];

  wave_generator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .n_pulses    (n_pulses),
    .busy        (busy),
    .done        (done),
    .wave        (wave),
    .pulses_left (pulses_left)
  );

  always #5 clk = ~clk;

  function automatic void push_ev(int kind, int val, int aux);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.aux  = aux;
    exp_q.push_back(e);
  endfunction

  function automatic void check_val(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endfunction

  // Monitor: turns the sampled waveform into high/low/end events and scores them.
  function automatic void got_ev(int kind, int val, int aux);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d aux=%0d expected none", kind, val, aux);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.aux != aux) begin
        errors++;
        $display("FAIL event: got kind=%0d val=%0d aux=%0d expected kind=%0d val=%0d aux=%0d",
                 kind, val, aux, e.kind, e.val, e.aux);
      end
    end
  endfunction

  int   hi_cnt = 0;
  int   lo_cnt = 0;
  int   busy_cnt = 0;
  int   pl_cap = 0;
  logic prev_wave = 1'b0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done && busy) begin
      checks++;
      errors++;
      $display("FAIL done_with_busy: got done=1 busy=1 expected busy=0");
    end
    if (wave) begin
      if (!prev_wave) begin
        pl_cap = int'(pulses_left);
        if (lo_cnt > 0) got_ev(EV_LOW, lo_cnt, 0);
        lo_cnt = 0;
      end
      hi_cnt++;
    end else begin
      if (prev_wave) begin
        got_ev(EV_HIGH, hi_cnt, pl_cap);
        hi_cnt = 0;
      end
      if (busy) lo_cnt++;
    end
    if (prev_busy && !busy) begin
      if (done && lo_cnt > 0) got_ev(EV_LOW, lo_cnt, 0);
      lo_cnt = 0;
      got_ev(EV_END, busy_cnt, int'(done));
      busy_cnt = 0;
    end
    prev_wave = wave;
    prev_busy = busy;
  end

  task automatic start_burst(input int h, input int l, input int n);
    @(negedge clk);
    high_cycles = h;
    low_cycles  = l;
    n_pulses    = n[15:0];
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within %0d cycles", budget);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int r;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check_val("reset_wave", int'(wave), 0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    check_val("reset_pulses_left", int'(pulses_left), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single pulse
    push_ev(EV_HIGH, 3, 1); push_ev(EV_LOW, 2, 0); push_ev(EV_END, 5, 1);
    start_burst(3, 2, 1);
    wait_idle(100);

    // Burst of four at period 2
    for (int i = 4; i >= 1; i--) begin
      push_ev(EV_HIGH, 1, i); push_ev(EV_LOW, 1, 0);
    end
    push_ev(EV_END, 8, 1);
    start_burst(1, 1, 4);
    wait_idle(100);

    // Zero lengths clamp to one cycle
    push_ev(EV_HIGH, 1, 2); push_ev(EV_LOW, 1, 0);
    push_ev(EV_HIGH, 1, 1); push_ev(EV_LOW, 1, 0);
    push_ev(EV_END, 4, 1);
    start_burst(0, 0, 2);
    wait_idle(100);

    // Continuous: 7 periods plus 3 cycles of high, then stop; mid-run start ignored
    for (int i = 0; i < 7; i++) begin
      push_ev(EV_HIGH, 5, 0); push_ev(EV_LOW, 5, 0);
    end
    push_ev(EV_HIGH, 3, 0); push_ev(EV_END, 73, 0);
    start_burst(5, 5, 0);
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1; high_cycles = 1; low_cycles = 1; n_pulses = 1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (51) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    check_val("stop_wave", int'(wave), 0);
    check_val("stop_busy", int'(busy), 0);
    check_val("stop_done", int'(done), 0);
    check_val("stop_pulses_left", int'(pulses_left), 0);
    repeat (3) @(posedge clk);

    // High-phase width as a pulse-width counter would see it
    push_ev(EV_HIGH, 37, 1); push_ev(EV_LOW, 11, 0); push_ev(EV_END, 48, 1);
    start_burst(37, 11, 1);
    wait_idle(200);
    for (int i = 0; i < 2; i++) begin
      r = $urandom_range(1000, 1);
      push_ev(EV_HIGH, r, 1); push_ev(EV_LOW, 3, 0); push_ev(EV_END, r + 3, 1);
      start_burst(r, 3, 1);
      wait_idle(1100);
    end

    // start held high: ignored while busy, accepted in the cycle after done
    push_ev(EV_HIGH, 2, 1); push_ev(EV_LOW, 1, 0); push_ev(EV_END, 3, 1);
    push_ev(EV_HIGH, 2, 1); push_ev(EV_LOW, 1, 0); push_ev(EV_END, 3, 1);
    @(negedge clk);
    high_cycles = 2; low_cycles = 1; n_pulses = 1; start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!done && n < 50);
    check_val("b2b_done_seen", int'(done), 1);
    @(posedge clk);
    #1 start = 1'b0;
    check_val("b2b_restart_busy", int'(busy), 1);
    check_val("b2b_restart_wave", int'(wave), 1);
    wait_idle(100);

    // Reset mid-Low, then start together with stop
    push_ev(EV_HIGH, 2, 1); push_ev(EV_END, 6, 0);
    start_burst(2, 20, 1);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_wave", int'(wave), 0);
    check_val("midrst_busy", int'(busy), 0);
    check_val("midrst_done", int'(done), 0);
    check_val("midrst_pulses_left", int'(pulses_left), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; stop = 1'b1; n_pulses = 3;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
    check_val("startstop_busy", int'(busy), 0);
    check_val("startstop_wave", int'(wave), 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("startstop_busy_later", int'(busy), 0);
    check_val("startstop_pulses_left", int'(pulses_left), 0);

    repeat (3) @(posedge clk);
    check_val("events_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
